// File: rtl/l2_arb_pkg.sv
// ----------------------------------------------------------------------
// l2_arb_pkg : shared types for the round-robin L2 arbiter
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package l2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ----------------------------------------------------------------------
// rr_pick : combinational round-robin picker (rotate / first-one / unrotate)
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module rr_pick #(
  parameter int NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic                      valid,
  output logic [$clog2(NUM_CH)-1:0] index
);

  localparam int IW = $clog2(NUM_CH);
  localparam logic [IW:0] c_num = (IW+1)'(NUM_CH);

  logic [2*NUM_CH-1:0] w_dbl;
  logic [NUM_CH-1:0]   w_rot;
  logic [IW-1:0]       w_first;
  logic [IW:0]         w_sum;
  logic [IW:0]         w_wrap;

  // Bit 0 of w_rot corresponds to the channel at ptr.
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[NUM_CH-1:0];

  always_comb begin
    w_first = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_first = i[IW-1:0];
      end
    end
  end

  assign w_sum  = {1'b0, w_first} + {1'b0, ptr};
  assign w_wrap = w_sum - c_num;
  assign index  = (w_sum >= c_num) ? w_wrap[IW-1:0] : w_sum[IW-1:0];
  assign valid  = |req;

endmodule

`default_nettype wire

// File: rtl/l2_rr_arbiter.sv
// ----------------------------------------------------------------------
// l2_rr_arbiter : round-robin N-channel arbiter onto a single L2 port
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module l2_rr_arbiter
  import l2_arb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 128
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  output logic [DATA_W-1:0]          ch_rdata,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic                       l2_read,
  output logic                       l2_write,
  output logic [ADDR_W-1:0]          l2_addr,
  output logic [DATA_W-1:0]          l2_wdata,
  input  logic [DATA_W-1:0]          l2_rdata,
  input  logic                       l2_resp,
  output logic [$clog2(NUM_CH)-1:0]  grant_id,
  output logic                       busy
);

  localparam int IW = $clog2(NUM_CH);
  localparam logic [IW-1:0] c_last = IW'(NUM_CH - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  op_t                 r_op;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_grant_id;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [NUM_CH-1:0]   w_req;
  logic                w_valid;
  logic [IW-1:0]       w_idx;

  assign w_req = ch_read | ch_write;

  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req   (w_req),
    .ptr   (r_rr_ptr),
    .valid (w_valid),
    .index (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= OP_READ;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_valid) begin
        // Write wins within a channel so a dirty eviction precedes its refill.
        r_op       <= ch_write[w_idx] ? OP_WRITE : OP_READ;
        r_addr     <= ch_addr[w_idx*ADDR_W +: ADDR_W];
        r_wdata    <= ch_wdata[w_idx*DATA_W +: DATA_W];
        r_grant_id <= w_idx;
      end
      if (r_state == XFER && l2_resp) begin
        r_rr_ptr <= (r_grant_id == c_last) ? '0 : r_grant_id + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    l2_read     = 1'b0;
    l2_write    = 1'b0;
    ch_resp     = '0;
    case (r_state)
      IDLE: begin
        if (w_valid) w_state_nxt = XFER;
      end
      XFER: begin
        l2_read  = (r_op == OP_READ);
        l2_write = (r_op == OP_WRITE);
        if (l2_resp) begin
          ch_resp[r_grant_id] = 1'b1;
          w_state_nxt         = DRAIN;
        end
      end
      DRAIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign ch_rdata = l2_rdata;
  assign l2_addr  = r_addr;
  assign l2_wdata = r_wdata;
  assign grant_id = r_grant_id;
  assign busy     = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_l2_rr_arbiter.sv
// ----------------------------------------------------------------------
// tb_l2_rr_arbiter : scoreboard bench for l2_rr_arbiter (4 channels)
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_l2_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 128;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    ch_read = '0;
  logic [N-1:0]    ch_write = '0;
  logic [N*AW-1:0] ch_addr = '0;
  logic [N*DW-1:0] ch_wdata = '0;
  logic [DW-1:0]   ch_rdata;
  logic [N-1:0]    ch_resp;
  logic            l2_read;
  logic            l2_write;
  logic [AW-1:0]   l2_addr;
  logic [DW-1:0]   l2_wdata;
  logic [DW-1:0]   l2_rdata = '0;
  logic            l2_resp = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;

  typedef struct {
    int             ch;
    bit             wr;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  l2_rr_arbiter #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ch_read  (ch_read),
    .ch_write (ch_write),
    .ch_addr  (ch_addr),
    .ch_wdata (ch_wdata),
    .ch_rdata (ch_rdata),
    .ch_resp  (ch_resp),
    .l2_read  (l2_read),
    .l2_write (l2_write),
    .l2_addr  (l2_addr),
    .l2_wdata (l2_wdata),
    .l2_rdata (l2_rdata),
    .l2_resp  (l2_resp),
    .grant_id (grant_id),
    .busy     (busy)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] wd(input int i);
    return {4{32'hC0DE_0000 + 32'(i)}};
  endfunction

  function automatic logic [DW-1:0] ln(input int i);
    return {4{32'hDA7A_0000 + 32'(i)}};
  endfunction

  task automatic set_ch(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ch_addr[i*AW +: AW]  = a;
    ch_wdata[i*DW +: DW] = d;
  endtask

  task automatic push(input int ch, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.ch = ch; e.wr = wr; e.addr = a; e.wdata = d;
    sb.push_back(e);
  endtask

  // Acts as the L2 and the requesters: waits for a strobe, checks it against
  // the next scoreboard entry, answers after lat cycles, then drops requests.
  task automatic do_xfer(input int lat, input logic [DW-1:0] line,
                         input logic [N-1:0] drop_rd, input logic [N-1:0] drop_wr,
                         input bit chg);
    exp_t e;
    int   n = 0;
    while (!(l2_read || l2_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("strobe_seen", DW'(l2_read | l2_write), 1);
    check("sb_nonempty", DW'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("grant_id", DW'(grant_id), DW'(e.ch));
    check("l2_write", DW'(l2_write), DW'(e.wr));
    check("l2_read", DW'(l2_read), DW'(!e.wr));
    if (e.wr) check("l2_wdata", l2_wdata, e.wdata);
    if (chg) ch_addr[e.ch*AW +: AW] = 16'hFFF0;
    for (int k = 0; k < lat; k++) begin
      check("l2_addr_xfer", DW'(l2_addr), DW'(e.addr));
      check("resp_early", DW'(ch_resp), 0);
      @(negedge clk);
    end
    l2_rdata = line;
    l2_resp  = 1'b1;
    #1;
    check("ch_resp", DW'(ch_resp), DW'(1 << e.ch));
    if (!e.wr) check("ch_rdata", ch_rdata, line);
    ch_read  = ch_read & ~drop_rd;
    ch_write = ch_write & ~drop_wr;
    @(negedge clk);
    l2_resp = 1'b0;
    #1;
    check("drain_busy", DW'(busy), 1);
    check("drain_strobe", DW'(l2_read | l2_write), 0);
    check("drain_resp", DW'(ch_resp), 0);
    check("drain_addr", DW'(l2_addr), DW'(e.addr));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", DW'(busy), 0);
    check("rst_strobe", DW'(l2_read | l2_write), 0);
    check("rst_resp", DW'(ch_resp), 0);
    check("rst_grant", DW'(grant_id), 0);
    check("rst_addr", DW'(l2_addr), 0);
    check("rst_wdata", l2_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single icache read
    set_ch(0, 16'h1230, wd(0));
    ch_read = 4'b0001;
    push(0, 1'b0, 16'h1230, wd(0));
    @(negedge clk);
    check("t1_latency", DW'(l2_read), 1);
    do_xfer(3, {16{8'hA5}}, 4'b0001, 4'b0000, 1'b0);
    @(negedge clk);
    check("t1_idle", DW'(busy), 0);

    // Both channels held from reset: strict alternation
    pulse_reset();
    set_ch(0, 16'h0100, wd(1));
    set_ch(1, 16'h0200, wd(2));
    ch_read = 4'b0011;
    push(0, 1'b0, 16'h0100, wd(1));
    push(1, 1'b0, 16'h0200, wd(2));
    push(0, 1'b0, 16'h0100, wd(1));
    push(1, 1'b0, 16'h0200, wd(2));
    do_xfer(1, ln(1), 4'b0000, 4'b0000, 1'b0);
    do_xfer(2, ln(2), 4'b0000, 4'b0000, 1'b0);
    do_xfer(1, ln(3), 4'b0000, 4'b0000, 1'b0);
    do_xfer(2, ln(4), 4'b0011, 4'b0000, 1'b0);

    // Dirty miss on dcache: write first, then read
    set_ch(1, 16'h4000, wd(5));
    ch_write = 4'b0010;
    ch_read  = 4'b0010;
    push(1, 1'b1, 16'h4000, wd(5));
    push(1, 1'b0, 16'h4000, wd(5));
    do_xfer(2, ln(5), 4'b0000, 4'b0010, 1'b0);
    do_xfer(2, ln(6), 4'b0010, 4'b0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_no_extra_resp", DW'(ch_resp), 0);
      check("t3_idle", DW'(busy), 0);
    end

    // Address change during XFER must not reach l2_addr
    set_ch(1, 16'h0040, wd(7));
    ch_read = 4'b0010;
    push(1, 1'b0, 16'h0040, wd(7));
    do_xfer(3, ln(7), 4'b0010, 4'b0000, 1'b1);

    // Reset mid-XFER (rr_ptr is 2 beforehand)
    set_ch(1, 16'h0777, wd(8));
    ch_read = 4'b0010;
    for (int k = 0; k < 10 && !l2_read; k++) @(negedge clk);
    check("t5_grant", DW'(grant_id), 1);
    check("t5_read", DW'(l2_read), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_read_drop", DW'(l2_read), 0);
    check("t5_busy_drop", DW'(busy), 0);
    ch_read = 4'b0000;
    @(negedge clk);
    #2 rst_n = 1'b1;
    check("t5_addr_clr", DW'(l2_addr), 0);
    check("t5_grant_clr", DW'(grant_id), 0);
    @(negedge clk);
    l2_resp = 1'b1;
    #1;
    check("t5_late_resp", DW'(ch_resp), 0);
    @(negedge clk);
    l2_resp = 1'b0;
    set_ch(0, 16'h0A00, wd(9));
    set_ch(2, 16'h0C00, wd(10));
    ch_read = 4'b0101;
    push(0, 1'b0, 16'h0A00, wd(9));
    push(2, 1'b0, 16'h0C00, wd(10));
    do_xfer(1, ln(9), 4'b0001, 4'b0000, 1'b0);
    do_xfer(1, ln(10), 4'b0100, 4'b0000, 1'b0);

    // All four reading with rr_ptr=3: wrap-around order 3,0,1,2
    for (int i = 0; i < N; i++) set_ch(i, 16'h3000 + 16'(i), wd(20 + i));
    ch_read = 4'b1111;
    push(3, 1'b0, 16'h3003, wd(23));
    push(0, 1'b0, 16'h3000, wd(20));
    push(1, 1'b0, 16'h3001, wd(21));
    push(2, 1'b0, 16'h3002, wd(22));
    do_xfer(1, ln(11), 4'b0000, 4'b0000, 1'b0);
    do_xfer(2, ln(12), 4'b0000, 4'b0000, 1'b0);
    do_xfer(1, ln(13), 4'b0000, 4'b0000, 1'b0);
    do_xfer(2, ln(14), 4'b1111, 4'b0000, 1'b0);

    // Spurious l2_resp while idle
    repeat (3) @(negedge clk);
    l2_resp = 1'b1;
    #1;
    check("t6_spurious_resp", DW'(ch_resp), 0);
    check("t6_idle", DW'(busy), 0);
    @(negedge clk);
    l2_resp = 1'b0;
    check("sb_drained", DW'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
